wb_arb2_rr: RTL
===============

# wb_arb2_rr

Two-master round-robin Wishbone arbiter in front of a single pipelined Wishbone register-bank slave (32-bit data, 4-bit select). It grants one master at a time and forwards exactly one transaction per grant. It returns the slave's ack/err/rty and read data to the granted master, and generates an error on a watchdog timeout. Sits between CPU/debug masters and a generated register block.

## Interface
- AW, 4: address width of master and slave ports.
- TIMEOUT, 16: cycles in REQ+WAIT before forced error; legal range 2..255.

- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_sel_i  in  4  master 0 byte select.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_ack_o, m0_err_o, m0_rty_o, m0_stall_o  out  1 each  master 0 responses.
- m0_dat_o  out  32  master 0 read data.
- m1_*: identical set for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls.
- s_sel_o  out  4  slave byte select.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  32  slave write data.
- s_ack_i, s_err_i, s_rty_i, s_stall_i  in  1 each  slave responses.
- s_dat_i  in  32  slave read data.

## Operation
- Request: reqN = mN_cyc_i & mN_stb_i.
- FSM has four states: IDLE, REQ, WAIT, RESP.
- Registered state: owner (1 bit) and last (1 bit).
- IDLE:
  - Exactly one req: grant that master.
  - Both req: grant ~last.
  - On grant: owner := granted master; last := granted master; capture we/sel/adr/dat of the granted master into the s_* registers; timer := 0; go to REQ.
- REQ: s_cyc_o=1, s_stb_o=1.
  - s_stall_i=0: transaction accepted; go to WAIT.
  - If s_ack_i/s_err_i/s_rty_i is also 1 in the accepting cycle, treat it as completion and go to RESP.
- WAIT: s_cyc_o=1, s_stb_o=0. On s_ack_i, s_err_i or s_rty_i: capture s_dat_i and the response type, go to RESP.
- RESP: s_cyc_o=0. Exactly one of mOwner_ack_o/err_o/rty_o=1 for this single cycle; mOwner_dat_o holds the captured data. Next state is IDLE.
- Timeout: timer increments in every REQ/WAIT cycle. If timer reaches TIMEOUT-1 with no response, go to RESP with err=1 and dat=0. s_cyc_o drops in that RESP cycle.
- Abort: owner deasserts cyc in REQ/WAIT.
  - Go to IDLE next cycle; s_cyc_o/s_stb_o become 0.
  - No response is returned to the master; any late slave response is ignored.
- Stall: mN_stall_o = reqN & ~(state==REQ & owner==N & ~s_stall_i). This is combinational, so stall is low only in the cycle the slave accepts that master's strobe.
- Non-owner master: response outputs stay 0 at all times.
- mN_dat_o: holds its last value except in RESP, where the owner's port updates.
- Slave responses arriving in IDLE/RESP are ignored.
- Reset (asynchronous, any state, mid-transaction included):
  - state=IDLE, owner=0, last=1, timer=0.
  - All s_* outputs 0; all m*_ack/err/rty 0; m*_dat_o 0.
  - m*_stall_o follows its combinational equation, so it equals reqN while in IDLE.
  - last=1 means master 0 wins the first tie.

## Timing
- A request seen in IDLE at cycle N gives s_stb_o=1 at N+1.
- If the slave does not stall, the master's stall is low at N+1 and the FSM is in WAIT at N+2.
- A slave response at cycle K (K ≥ N+1) gives the master response at K+1. IDLE is at K+2; the earliest next strobe is at K+3.
- Minimum turnaround: 4 cycles per transaction with a zero-wait slave that acks the cycle after accept.
- Timeout: err is asserted TIMEOUT cycles after entering REQ.
- One outstanding transaction at a time; no pipelining across grants.
- All outputs are registered except m*_stall_o.

## Test plan
- Single read, m0:
  - Stimulus: adr=0x0, slave returns ack one cycle after accept with s_dat_i=0xDEADBEEF.
  - Required: m0_ack_o one cycle after s_ack_i; m0_dat_o=0xDEADBEEF; s_cyc_o low in the ack cycle; m1 outputs stay 0.
- Contention:
  - Stimulus: both masters write continuously (m0 dat=0x11111111, m1 dat=0x22222222).
  - Required: slave sees writes alternate, 0x11111111 first; each master gets one ack per grant.
- Slave stall:
  - Stimulus: s_stall_i held 1 for 3 cycles after REQ entry.
  - Required: s_stb_o stays 1 and owner stall stays 1 for 3 cycles, then stall falls for exactly one cycle; one ack follows.
- Timeout:
  - Stimulus: TIMEOUT=16, slave never responds.
  - Required: m0_err_o pulses 16 cycles after REQ entry; m0_dat_o=0; FSM returns to IDLE; the next request is served normally.
- Abort and late response:
  - Stimulus: m1 drops cyc in WAIT, then a stray s_ack_i arrives.
  - Required: s_cyc_o is 0 next cycle; no m1_ack_o; m0's next transaction is unaffected.
- Reset mid-transaction:
  - Stimulus: rst_n_i low in WAIT.
  - Required: s_cyc_o/s_stb_o=0 immediately without a clock edge; after release with both requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_arb2_rr.sv
// -----------------------------------------------------------------------------
// wb_arb2_rr
//
// Round-robin arbiter that lets two Wishbone masters share one pipelined
// Wishbone register-bank slave. Each grant forwards exactly one transaction.
// The slave's ack/err/rty and read data go back to the granted master.
// A watchdog turns a slave that never answers into an err response.
//
// Handshake: a master request (cyc & stb) is the "valid" and ~stall is the
// "ready". A strobe transfers on the rising edge where both are high. The
// master holds we/sel/adr/dat stable while it is stalled. The slave side
// follows the same rule with s_stb_o as valid and ~s_stall_i as ready.
//
// Parameters
//   AW       address width of the master and slave ports
//   TIMEOUT  cycles spent in REQ+WAIT before a forced err (2..255)
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*           master ports: cyc/stb/we/sel/adr/dat in;
//                         ack/err/rty/stall/dat out
//   s_*                   slave port: cyc/stb/we/sel/adr/dat out;
//                         ack/err/rty/stall/dat in
//   dbg_state_o           current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
// -----------------------------------------------------------------------------
module wb_arb2_rr #(
   parameter int AW      = 4,
   parameter int TIMEOUT = 16
) (
   input  logic          clk_i,
   input  logic          rst_n_i,

   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [3:0]    m0_sel_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [31:0]   m0_dat_i,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   output logic          m0_rty_o,
   output logic          m0_stall_o,
   output logic [31:0]   m0_dat_o,

   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [3:0]    m1_sel_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [31:0]   m1_dat_i,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          m1_rty_o,
   output logic          m1_stall_o,
   output logic [31:0]   m1_dat_o,

   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [3:0]    s_sel_o,
   output logic [AW-1:0] s_adr_o,
   output logic [31:0]   s_dat_o,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   input  logic          s_rty_i,
   input  logic          s_stall_i,
   input  logic [31:0]   s_dat_i,

   output logic [1:0]    dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // The timer counts from 0, so it expires on its TIMEOUT-th REQ/WAIT cycle.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   state_t      state_d;
   logic        owner_q;
   logic        last_q;
   logic [7:0]  timer_q;

   logic        req0;
   logic        req1;
   logic        own_cyc;
   logic        slv_rsp;
   logic        timer_done;
   logic        accept_now;

   logic        grant;
   logic        grant_sel;
   logic        rsp_load;
   logic        rsp_ack;
   logic        rsp_err;
   logic        rsp_rty;
   logic [31:0] rsp_dat;

   assign req0       = m0_cyc_i & m0_stb_i;
   assign req1       = m1_cyc_i & m1_stb_i;
   assign own_cyc    = owner_q ? m1_cyc_i : m0_cyc_i;
   assign slv_rsp    = s_ack_i | s_err_i | s_rty_i;
   assign timer_done = (timer_q == TIMER_LAST);
   assign accept_now = (state_q == ST_REQ) & ~s_stall_i;

   // Stall drops only in the cycle the slave takes this master's strobe.
   assign m0_stall_o = req0 & ~(accept_now & ~owner_q);
   assign m1_stall_o = req1 & ~(accept_now & owner_q);

   assign dbg_state_o = state_q;

   // Next-state and response selection.
   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      grant_sel = 1'b0;
      rsp_load  = 1'b0;
      rsp_ack   = 1'b0;
      rsp_err   = 1'b0;
      rsp_rty   = 1'b0;
      rsp_dat   = '0;
      case (state_q)
         ST_IDLE: begin
            if (req0 | req1) begin
               grant     = 1'b1;
               // On a tie the master that did not win last time goes next.
               grant_sel = (req0 & req1) ? ~last_q : req1;
               state_d   = ST_REQ;
            end
         end
         ST_REQ, ST_WAIT: begin
            if (!own_cyc) begin
               // Owner walked away: drop the bus, return nothing.
               state_d = ST_IDLE;
            end else if (slv_rsp && (state_q == ST_WAIT || !s_stall_i)) begin
               // A response while still stalled is not tied to our strobe.
               state_d  = ST_RESP;
               rsp_load = 1'b1;
               // Only one response type goes back: ack, then err, then rty.
               rsp_ack  = s_ack_i;
               rsp_err  = ~s_ack_i & s_err_i;
               rsp_rty  = ~s_ack_i & ~s_err_i & s_rty_i;
               rsp_dat  = s_dat_i;
            end else if (timer_done) begin
               state_d  = ST_RESP;
               rsp_load = 1'b1;
               rsp_err  = 1'b1;
            end else if (state_q == ST_REQ && !s_stall_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            owner_q <= grant_sel;
            last_q  <= grant_sel;
            timer_q <= '0;
         end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
            timer_q <= timer_q + 8'd1;
         end
      end
   end

   // Slave-side outputs. cyc/stb are registered from the next state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s_cyc_o <= 1'b0;
         s_stb_o <= 1'b0;
         s_we_o  <= 1'b0;
         s_sel_o <= '0;
         s_adr_o <= '0;
         s_dat_o <= '0;
      end else begin
         s_cyc_o <= (state_d == ST_REQ) || (state_d == ST_WAIT);
         s_stb_o <= (state_d == ST_REQ);
         if (grant) begin
            s_we_o  <= grant_sel ? m1_we_i  : m0_we_i;
            s_sel_o <= grant_sel ? m1_sel_i : m0_sel_i;
            s_adr_o <= grant_sel ? m1_adr_i : m0_adr_i;
            s_dat_o <= grant_sel ? m1_dat_i : m0_dat_i;
         end
      end
   end

   // Master-side responses. These pulse for the single RESP cycle. Read data
   // is held until the next response to the same master.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m0_ack_o <= 1'b0;
         m0_err_o <= 1'b0;
         m0_rty_o <= 1'b0;
         m0_dat_o <= '0;
         m1_ack_o <= 1'b0;
         m1_err_o <= 1'b0;
         m1_rty_o <= 1'b0;
         m1_dat_o <= '0;
      end else begin
         m0_ack_o <= rsp_load & ~owner_q & rsp_ack;
         m0_err_o <= rsp_load & ~owner_q & rsp_err;
         m0_rty_o <= rsp_load & ~owner_q & rsp_rty;
         m1_ack_o <= rsp_load & owner_q & rsp_ack;
         m1_err_o <= rsp_load & owner_q & rsp_err;
         m1_rty_o <= rsp_load & owner_q & rsp_rty;
         if (rsp_load && !owner_q) m0_dat_o <= rsp_dat;
         if (rsp_load && owner_q)  m1_dat_o <= rsp_dat;
      end
   end

endmodule
